// File: rtl/motion_executor_if.sv
// Motion command bundle from a driving-mode controller to motion_executor.
// The controller drives every signal (master); the executor only observes them (slave).
// All signals are plain levels sampled on the rising edge of the shared clock.
// There is no valid/ready pair: the executor samples every cycle and never back-pressures.
// A turn request is a 0->1 transition of degree, with clockwise qualifying that same cycle.
interface motion_executor_if;
   logic [1:0] state;          // 00 OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING
   logic       move_forward;   // level, forward command
   logic       move_backward;  // level, backward command
   logic       clockwise;      // turn direction: 1 right, 0 left
   logic       degree;         // rising edge requests one 90 degree turn

   modport master (
      output state,
      output move_forward,
      output move_backward,
      output clockwise,
      output degree
   );

   modport slave (
      input state,
      input move_forward,
      input move_backward,
      input clockwise,
      input degree
   );
endinterface

// File: rtl/motion_executor.sv
// motion_executor: turns motion commands into registered actuation outputs.
// It executes fixed-length 90 degree turns, tracks a 2-bit heading and
// accumulates mileage while the car moves.
// Optional feature macro: MOTION_MILEAGE_EN compiles in the mileage prescaler
// and counter; without it mileage_o is tied to zero.
// Pipeline: stage one holds the FSM, turn counter, turn direction, internal
// heading and degree history; stage two registers every output from stage one
// plus the current command levels, so all outputs lag their cause by one cycle.
module motion_executor #(
   parameter int unsigned TURN_CYCLES = 100_000_000,
   parameter int unsigned MILE_TICK   = 50_000_000,
   parameter int unsigned MILE_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   motion_executor_if.slave      cmd_i,
   output logic                  drive_fwd_o,
   output logic                  drive_bwd_o,
   output logic                  turn_right_o,
   output logic                  turn_left_o,
   output logic                  busy_o,
   output logic [1:0]            heading_o,
   output logic [MILE_WIDTH-1:0] mileage_o,
   output logic [1:0]            fsm_state_o
);

   // Turn counter only has to hold TURN_CYCLES-1.
   localparam int unsigned CW = (TURN_CYCLES > 2) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);

   // Reject parameter values the timing scheme cannot honour.
   if (TURN_CYCLES < 2) begin : g_bad_turn
      $error("motion_executor: TURN_CYCLES must be at least 2");
   end
   if (MILE_TICK < 1) begin : g_bad_tick
      $error("motion_executor: MILE_TICK must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2
   } fsm_e;

   fsm_e          fsm_q, fsm_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;        // 1 = right turn in progress
   logic [1:0]    hdg_q, hdg_d;        // heading as the FSM sees it
   logic          degree_q;            // degree seen last cycle

   logic          moving;
   logic          turn_req;

   logic          drive_fwd_q, drive_fwd_d;
   logic          drive_bwd_q, drive_bwd_d;
   logic          turn_right_q, turn_right_d;
   logic          turn_left_q, turn_left_d;
   logic          busy_q, busy_d;
   logic [1:0]    heading_q, heading_d;

   assign moving   = (cmd_i.state == 2'b11);
   assign turn_req = cmd_i.degree & ~degree_q;

   // State register: FSM, turn counter, direction, heading and degree history.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q    <= ST_IDLE;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         hdg_q    <= 2'b00;
         degree_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         hdg_q    <= hdg_d;
         degree_q <= cmd_i.degree;
      end
   end

   // Next-state logic: enter/leave motion, start, time and finish turns.
   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      dir_d = dir_q;
      hdg_d = hdg_q;
      case (fsm_q)
         ST_IDLE: begin
            // A degree already high here is swallowed: degree_q catches up
            // this cycle, so only a fresh edge in DRIVE starts a turn.
            if (moving) begin
               fsm_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (!moving) begin
               fsm_d = ST_IDLE;
            end else if (turn_req) begin
               fsm_d = ST_TURN;
               cnt_d = TURN_LOAD;
               dir_d = cmd_i.clockwise;
            end
         end
         ST_TURN: begin
            // degree edges are not looked at here, so they are dropped.
            if (!moving) begin
               fsm_d = ST_IDLE;
               cnt_d = '0;
            end else if (cnt_q == '0) begin
               fsm_d = ST_DRIVE;
               hdg_d = dir_q ? (hdg_q + 2'd1) : (hdg_q - 2'd1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            fsm_d = ST_IDLE;
            cnt_d = '0;
         end
      endcase
      // Power off forgets where the car was pointing.
      if (cmd_i.state == 2'b00) begin
         hdg_d = 2'b00;
      end
   end

   // Output decode: actuation from the FSM state and the live commands.
   always_comb begin
      drive_fwd_d  = 1'b0;
      drive_bwd_d  = 1'b0;
      turn_right_d = 1'b0;
      turn_left_d  = 1'b0;
      busy_d       = 1'b0;
      heading_d    = hdg_q;
      if (fsm_q != ST_IDLE) begin
         // Both commands high cancel each other out.
         drive_fwd_d = cmd_i.move_forward & ~cmd_i.move_backward;
         drive_bwd_d = cmd_i.move_backward & ~cmd_i.move_forward;
      end
      if (fsm_q == ST_TURN) begin
         turn_right_d = dir_q;
         turn_left_d  = ~dir_q;
         busy_d       = 1'b1;
      end
   end

   // Output register stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         drive_fwd_q  <= 1'b0;
         drive_bwd_q  <= 1'b0;
         turn_right_q <= 1'b0;
         turn_left_q  <= 1'b0;
         busy_q       <= 1'b0;
         heading_q    <= 2'b00;
      end else begin
         drive_fwd_q  <= drive_fwd_d;
         drive_bwd_q  <= drive_bwd_d;
         turn_right_q <= turn_right_d;
         turn_left_q  <= turn_left_d;
         busy_q       <= busy_d;
         heading_q    <= heading_d;
      end
   end

   assign drive_fwd_o  = drive_fwd_q;
   assign drive_bwd_o  = drive_bwd_q;
   assign turn_right_o = turn_right_q;
   assign turn_left_o  = turn_left_q;
   assign busy_o       = busy_q;
   assign heading_o    = heading_q;
   assign fsm_state_o  = fsm_q;

`ifdef MOTION_MILEAGE_EN
   localparam int unsigned PW = (MILE_TICK > 1) ? $clog2(MILE_TICK) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(MILE_TICK - 1);

   logic                  off_q;        // OFF seen last cycle, aligned with heading_o
   logic [PW-1:0]         pre_q;
   logic [MILE_WIDTH-1:0] mileage_q;

   // Mileage: count moving output cycles, bump a saturating distance counter.
   // The prescaler keeps its partial count across stops and power-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         off_q     <= 1'b0;
         pre_q     <= '0;
         mileage_q <= '0;
      end else begin
         off_q <= (cmd_i.state == 2'b00);
         if (off_q) begin
            mileage_q <= '0;
         end else if (drive_fwd_q | drive_bwd_q) begin
            if (pre_q == TICK_LAST) begin
               pre_q <= '0;
               if (mileage_q != '1) begin
                  mileage_q <= mileage_q + MILE_WIDTH'(1);
               end
            end else begin
               pre_q <= pre_q + PW'(1);
            end
         end
      end
   end

   assign mileage_o = mileage_q;
`else
   assign mileage_o = '0;
`endif

endmodule

// File: tb/tb_motion_executor.sv
// Bench for motion_executor: directed scenarios plus random command traffic,
// every cycle compared against a remaining-cycles reference model.
module tb_motion_executor;

   localparam int TC  = 4;   // turn length in cycles
   localparam int MT  = 3;   // moving cycles per mileage unit
   localparam int MWA = 8;
   localparam int MWB = 2;   // narrow instance to exercise saturation
`ifdef MOTION_MILEAGE_EN
   localparam int MILE_ON = 1;
`else
   localparam int MILE_ON = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   motion_executor_if cmd ();

   logic       fwd_a, bwd_a, tr_a, tl_a, busy_a;
   logic [1:0] hd_a, fsm_a;
   logic [MWA-1:0] mil_a;
   logic       fwd_b, bwd_b, tr_b, tl_b, busy_b;
   logic [1:0] hd_b, fsm_b;
   logic [MWB-1:0] mil_b;

   motion_executor #(.TURN_CYCLES(TC), .MILE_TICK(MT), .MILE_WIDTH(MWA)) dut_a (
      .clk(clk), .rst(rst), .cmd_i(cmd),
      .drive_fwd_o(fwd_a), .drive_bwd_o(bwd_a), .turn_right_o(tr_a), .turn_left_o(tl_a),
      .busy_o(busy_a), .heading_o(hd_a), .mileage_o(mil_a), .fsm_state_o(fsm_a)
   );

   motion_executor #(.TURN_CYCLES(TC), .MILE_TICK(MT), .MILE_WIDTH(MWB)) dut_b (
      .clk(clk), .rst(rst), .cmd_i(cmd),
      .drive_fwd_o(fwd_b), .drive_bwd_o(bwd_b), .turn_right_o(tr_b), .turn_left_o(tl_b),
      .busy_o(busy_b), .heading_o(hd_b), .mileage_o(mil_b), .fsm_state_o(fsm_b)
   );

   // ---------------- scoreboard counters / checker ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // engaged: car has been in MOVING long enough to actuate
   // rem: remaining turn cycles still to be shown on the turn output
   int m_engaged, m_rem, m_cw, m_hd, m_prev_deg, m_off_prev, m_pres, m_mile_a, m_mile_b;
   int e_fwd, e_bwd, e_tr, e_tl, e_busy, e_hd;

   task automatic model_reset();
      m_engaged = 0; m_rem = 0; m_cw = 0; m_hd = 0; m_prev_deg = 0;
      m_off_prev = 0; m_pres = 0; m_mile_a = 0; m_mile_b = 0;
      e_fwd = 0; e_bwd = 0; e_tr = 0; e_tl = 0; e_busy = 0; e_hd = 0;
   endtask

   task automatic model_edge();
      int st, mf, mb, dg;
      st = int'(cmd.state); mf = int'(cmd.move_forward);
      mb = int'(cmd.move_backward); dg = int'(cmd.degree);
      // distance: counted from what the outputs showed during the last cycle
      if (MILE_ON != 0) begin
         if (m_off_prev != 0) begin
            m_mile_a = 0; m_mile_b = 0;
         end else if (e_fwd != 0 || e_bwd != 0) begin
            m_pres++;
            if (m_pres == MT) begin
               m_pres = 0;
               if (m_mile_a < (1 << MWA) - 1) m_mile_a++;
               if (m_mile_b < (1 << MWB) - 1) m_mile_b++;
            end
         end
      end
      // visible outputs after this edge
      e_fwd  = (m_engaged != 0 && mf == 1 && mb == 0) ? 1 : 0;
      e_bwd  = (m_engaged != 0 && mb == 1 && mf == 0) ? 1 : 0;
      e_busy = (m_rem > 0) ? 1 : 0;
      e_tr   = (m_rem > 0 && m_cw != 0) ? 1 : 0;
      e_tl   = (m_rem > 0 && m_cw == 0) ? 1 : 0;
      e_hd   = m_hd;
      // internal progress
      m_off_prev = (st == 0) ? 1 : 0;
      if (st != 3) begin
         m_engaged = 0; m_rem = 0;
      end else if (m_engaged == 0) begin
         m_engaged = 1;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) m_hd = (m_hd + ((m_cw != 0) ? 1 : 3)) % 4;
      end else if (dg == 1 && m_prev_deg == 0) begin
         m_rem = TC; m_cw = int'(cmd.clockwise);
      end
      if (st == 0) m_hd = 0;
      m_prev_deg = dg;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
      check("fwd",    32'(fwd_a),  32'(e_fwd));
      check("bwd",    32'(bwd_a),  32'(e_bwd));
      check("tright", 32'(tr_a),   32'(e_tr));
      check("tleft",  32'(tl_a),   32'(e_tl));
      check("busy",   32'(busy_a), 32'(e_busy));
      check("head",   32'(hd_a),   32'(e_hd));
      check("mile_a", 32'(mil_a),  32'(m_mile_a));
      check("mile_b", 32'(mil_b),  32'(m_mile_b));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Issue one turn and run until its heading update is visible.
   task automatic turn_once(input logic cw, output int on_cycles);
      cmd.clockwise = cw;
      cmd.degree = 1'b1;
      tick();
      cmd.degree = 1'b0;
      on_cycles = 0;
      repeat (TC + 1) begin
         tick();
         if ((cw ? tr_a : tl_a) == 1'b1 && busy_a == 1'b1) on_cycles++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      cmd.state = 2'b00; cmd.move_forward = 1'b0; cmd.move_backward = 1'b0;
      cmd.clockwise = 1'b0; cmd.degree = 1'b0;
      model_reset();
      do_reset();
      check("rst_head", 32'(hd_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);

      // forward drive with one-cycle latency, then 9 moving cycles of mileage
      cmd.state = 2'b11; cmd.move_forward = 1'b1;
      tick();
      check("drv_latency", 32'(fwd_a), 32'd0);
      tick();
      check("drv_fwd", 32'(fwd_a), 32'd1);
      check("drv_bwd", 32'(bwd_a), 32'd0);
      check("drv_noturn", 32'(tr_a | tl_a | busy_a), 32'd0);
      repeat (8) tick();
      cmd.move_forward = 1'b0;
      tick();
      check("mile_nine", 32'(mil_a), 32'(3 * MILE_ON));

      // conflicting commands stop the car and freeze mileage
      cmd.move_forward = 1'b1; cmd.move_backward = 1'b1;
      repeat (6) tick();
      check("conf_fwd", 32'(fwd_a), 32'd0);
      check("conf_bwd", 32'(bwd_a), 32'd0);
      check("conf_mile", 32'(mil_a), 32'(3 * MILE_ON));
      cmd.move_forward = 1'b0; cmd.move_backward = 1'b0;

      // four right turns walk the heading around and wrap
      for (int i = 0; i < 4; i++) begin
         turn_once(1'b1, n);
         check("right_len", 32'(n), 32'(TC));
         check("right_head", 32'(hd_a), 32'((i + 1) % 4));
      end

      // one more right turn, then OFF clears heading and mileage
      turn_once(1'b1, n);
      cmd.state = 2'b00;
      tick();
      tick();
      check("off_head", 32'(hd_a), 32'd0);
      check("off_mile", 32'(mil_a), 32'd0);

      // left turn from north with a second degree edge mid-turn
      cmd.state = 2'b11;
      tick();
      cmd.clockwise = 1'b0;
      cmd.degree = 1'b1;
      tick();
      n = 0;
      for (int i = 0; i < TC + 1; i++) begin
         if (i == 1) cmd.degree = 1'b0;
         if (i == 2) cmd.degree = 1'b1;
         tick();
         if (tl_a == 1'b1) n++;
      end
      cmd.degree = 1'b0;
      check("left_len", 32'(n), 32'(TC));
      check("left_head", 32'(hd_a), 32'd3);
      repeat (3) tick();
      check("left_noqueue", 32'(busy_a), 32'd0);

      // abort mid-turn by leaving MOVING
      cmd.clockwise = 1'b1;
      cmd.degree = 1'b1;
      tick();
      cmd.degree = 1'b0;
      tick();
      tick();
      cmd.state = 2'b01;
      tick();
      check("abort_hold", 32'(busy_a), 32'd1);
      tick();
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_tr", 32'(tr_a), 32'd0);
      check("abort_head", 32'(hd_a), 32'd3);
      cmd.state = 2'b00;
      tick();
      tick();
      check("abort_off_head", 32'(hd_a), 32'd0);

      // long forward run saturates the narrow mileage counter
      cmd.state = 2'b11;
      tick();
      cmd.move_forward = 1'b1;
      repeat (20) tick();
      check("sat_mile_b", 32'(mil_b), 32'(3 * MILE_ON));
      cmd.move_forward = 1'b0;

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 19) == 0)
            cmd.state = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         if ($urandom_range(0, 3) == 0) cmd.move_forward = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) cmd.move_backward = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) cmd.degree = 1'($urandom_range(0, 1));
         cmd.clockwise = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/motion_executor.md
# motion_executor

Consumes the motion command interface driven by the manual driving-mode controller (`move_forward`, `move_backward`, `clockwise`, `degree`) and turns it into timed actuation outputs for the car simulator. Executes fixed-length 90° turns, tracks a 2-bit heading and accumulates mileage while moving. Sits between the driving-mode controllers and the simulator/UART output stage.

## Interface
- `TURN_CYCLES`, 100_000_000: cycles one 90° turn is held (1 s at 100 MHz); ≥ 2
- `MILE_TICK`, 50_000_000: moving cycles per mileage unit; ≥ 1
- `MILE_WIDTH`, 24: mileage counter width
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `state`  in  2  power/driving state: 00 OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING
- `move_forward`  in  1  level, forward command
- `move_backward`  in  1  level, backward command
- `clockwise`  in  1  turn direction qualifier: 1 right, 0 left
- `degree`  in  1  turn request; rising edge requests one 90° turn
- `drive_fwd`  out  1  forward actuation to simulator
- `drive_bwd`  out  1  backward actuation to simulator
- `turn_right`  out  1  right turn actuation
- `turn_left`  out  1  left turn actuation
- `busy`  out  1  high while a turn executes
- `heading`  out  2  00 N, 01 E, 10 S, 11 W
- `mileage`  out  MILE_WIDTH  accumulated distance units

## Operation
- FSM states: IDLE, DRIVE, TURN.
- IDLE: all actuation outputs 0. Entered when `state` ≠ 11.
- DRIVE (`state` = 11, no turn): `drive_fwd` = `move_forward & ~move_backward`; `drive_bwd` = `move_backward & ~move_forward`. Both commands high means both outputs 0 (conflict treated as stop).
- Turn request: rising edge of `degree` (registered `degree` last cycle 0, now 1) while in DRIVE. `clockwise` is sampled on that same cycle and held for the whole turn.
- TURN: the selected `turn_right`/`turn_left` is high; `drive_fwd`/`drive_bwd` keep following the commands, so turning in place and arc turns both work. `busy` = 1. A down-counter is loaded with TURN_CYCLES−1 and decrements each cycle.
- At counter 0: return to DRIVE; heading += 1 for right, −1 for left (mod 4, 11→00 and 00→11 wrap).
- `degree` edges during TURN are ignored, not queued.
- `state` leaving 11 mid-turn aborts: go to IDLE, heading unchanged, counter cleared.
- `state` = 00 (OFF) clears `heading` and `mileage` to 0. Other non-moving states retain both.
- Mileage: a prescaler counts cycles where `drive_fwd | drive_bwd`. At MILE_TICK−1 it wraps to 0 and `mileage` increments. `mileage` saturates at all-ones. The prescaler holds (does not clear) when motion stops.

## Timing
- Reset (synchronous, `rst` = 1 at a rising edge): FSM IDLE; all outputs 0; `heading` 00; `mileage` 0; prescaler, turn counter and `degree` history register cleared.
- All outputs are registered, with one-cycle latency from input sample to output.
- Rising edge of `degree` at edge k: turn output high from edge k+1 for exactly TURN_CYCLES cycles. `heading` updates on the edge where the turn output falls.
- DRIVE entry: the first edge with `state` = 11. Actuation follows one cycle later.
- A `degree` already high when DRIVE is entered does not trigger a turn; a fresh rising edge is required.

## Configuration
- `MOTION_MILEAGE_EN`: when defined, the prescaler and mileage counter are compiled in as described. When undefined, `mileage` is tied to 0, no counter logic exists, and MILE_TICK is unused. All other behaviour is identical.

## Test plan
- Reset, then `state`=11, `move_forward`=1 → `drive_fwd`=1 one cycle later; `drive_bwd`, turn outputs and `busy` stay 0.
- TURN_CYCLES=4, `clockwise`=1, `degree` pulse → `turn_right` and `busy` high exactly 4 cycles; `heading` 00→01. Repeat four times → `heading` wraps to 00.
- `clockwise`=0 from `heading`=00 → `turn_left` for TURN_CYCLES cycles, `heading`=11. A second `degree` edge mid-turn has no effect.
- Mid-turn `state`→01 → turn output drops next cycle, FSM IDLE, `heading` unchanged. `state`→00 → `heading` and `mileage` become 0.
- `move_forward`=`move_backward`=1 in MOVING → both drive outputs 0, mileage frozen.
- MILE_TICK=3, forward for 9 cycles → `mileage`=3 (with `MOTION_MILEAGE_EN`); without the macro `mileage` stays 0. MILE_WIDTH=2, run long enough → saturates at 3.
